// File: rtl/wisc_pkg.sv
// rtl/wisc_pkg.sv - shared WISC-15 widths, opcodes and fetch state encoding
package wisc_pkg;

  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 16;

  localparam logic [3:0] HLT_OPCODE = 4'hF;

  typedef enum logic {
    RUN,
    HALTED
  } fetch_state_e;

  function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1:INSTR_W-4];
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - instruction memory port plus fetch-to-decode handshake
interface instr_fetch_if;
  import wisc_pkg::*;

  logic [ADDR_W-1:0]  im_addr;
  logic               im_rd_en;
  logic [INSTR_W-1:0] im_instr;

  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic [ADDR_W-1:0]  if_pc;
  logic [ADDR_W-1:0]  if_pc_plus1;
  logic               dec_ready;

  modport master (
    output im_addr, im_rd_en, if_valid, if_instr, if_pc, if_pc_plus1,
    input  im_instr, dec_ready
  );

  modport slave (
    input  im_addr, im_rd_en, if_valid, if_instr, if_pc, if_pc_plus1,
    output im_instr, dec_ready
  );

endinterface

// File: rtl/if_buffer.sv
// rtl/if_buffer.sv - DEPTH-entry FIFO of {instr, pc} with flush and same-cycle push+pop
module if_buffer
  import wisc_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               push,
  input  logic [INSTR_W-1:0] push_instr,
  input  logic [ADDR_W-1:0]  push_pc,
  input  logic               pop,
  output logic [INSTR_W-1:0] head_instr,
  output logic [ADDR_W-1:0]  head_pc,
  output logic [CNT_W-1:0]   count,
  output logic               full
);

  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [ADDR_W-1:0]  pc_mem    [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic               empty;
  logic               do_push;
  logic               do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  // A full buffer still accepts a word when the head leaves in the same cycle.
  assign do_push = push && !flush && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      instr_mem[wr_ptr] <= push_instr;
      pc_mem[wr_ptr]    <= push_pc;
    end
  end

  assign head_instr = instr_mem[rd_ptr];
  assign head_pc    = pc_mem[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - WISC-15 fetch stage: PC, memory request, HLT stop and redirect flush
module instr_fetch
  import wisc_pkg::*;
#(
  parameter int               DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
  parameter logic [3:0]       HLT_OP   = HLT_OPCODE
) (
  input  logic              clk,
  input  logic              rst,
  instr_fetch_if.master     bus,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e      state;
  fetch_state_e      state_next;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] fetch_pc_next;
  logic              fetch;
  logic              head_valid;
  logic              pop;
  logic              buf_full;
  logic [CNT_W-1:0]  buf_count;

  assign head_valid = (buf_count != '0) && !rst;
  assign pop        = head_valid && bus.dec_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
    end
  end

  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    fetch         = 1'b0;
    halted        = (state == HALTED) && !rst;
    case (state)
      RUN: begin
        fetch = !redirect && !rst && (!buf_full || pop);
        if (fetch) begin
          fetch_pc_next = fetch_pc + ADDR_W'(1);
          // The HLT word itself is still pushed; only later fetches stop.
          if (opcode_of(bus.im_instr) == HLT_OP) state_next = HALTED;
        end
      end
      HALTED: fetch = 1'b0;
      default: state_next = RUN;
    endcase
    if (redirect) begin
      fetch_pc_next = redirect_pc;
      state_next    = RUN;
    end
  end

  if_buffer #(.DEPTH(DEPTH)) u_buffer (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect),
    .push       (fetch),
    .push_instr (bus.im_instr),
    .push_pc    (fetch_pc),
    .pop        (pop),
    .head_instr (bus.if_instr),
    .head_pc    (bus.if_pc),
    .count      (buf_count),
    .full       (buf_full)
  );

  assign bus.im_addr     = fetch_pc;
  assign bus.im_rd_en    = fetch;
  assign bus.if_valid    = head_valid;
  assign bus.if_pc_plus1 = bus.if_pc + ADDR_W'(1);

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch-side master of the instruction memory port. It owns the PC and drives the memory's addr/rd_en pair, then captures the returned instr word.
- Returned words go into a small prefetch buffer, handed to decode over a valid/ready handshake.
- Handles branch/jump redirect (buffer flush) and stops fetching after a HLT opcode.
- Sits between the instruction memory and the decode stage of the WISC-15 pipeline.

Parameters:
- DEPTH, 2, prefetch buffer entries (power of 2, >=2)
- RESET_PC, 16'h0000, PC loaded on reset
- HLT_OP, 4'hF, opcode (instr[15:12]) that halts fetch

Ports:
- clk  input  1  system clock; the memory latches on clk low
- rst  input  1  synchronous reset, active-high
- im_addr  output  16  word address to instruction memory
- im_rd_en  output  1  read request to instruction memory
- im_instr  input  16  memory data; valid at the rising edge that ends the request cycle
- if_valid  output  1  buffer head holds a valid instruction
- if_instr  output  16  head instruction
- if_pc  output  16  word address of the head instruction
- if_pc_plus1  output  16  if_pc+1, mod 2^16, for branch/link use
- dec_ready  input  1  decode accepts the head this cycle (pop when if_valid&dec_ready)
- redirect  input  1  taken branch/jump/exception; flush and refetch
- redirect_pc  input  16  new fetch address when redirect=1
- halted  output  1  fetch stopped by HLT

Interface decisions: one clock (clk). Reset (rst) is synchronous and active-high.

Behaviour:
- Registers:
  - fetch_pc
  - buffer of {instr, pc} pairs with rd_ptr/wr_ptr/count
  - state
- Reset values: fetch_pc=RESET_PC, count=0, pointers=0, state=RUN.
- Outputs during reset: if_valid=0, halted=0, im_rd_en=0.
- Memory timing: im_addr is always equal to fetch_pc (combinational).
  - A request in cycle N (im_rd_en=1) returns data that is sampled at the rising edge ending cycle N.
  - The fetch completes in that cycle: one-cycle latency, no outstanding requests.
- States:
  - RUN: im_rd_en = !redirect && (count<DEPTH || (if_valid&&dec_ready)).
    - On a fetch: push {im_instr, fetch_pc} and set fetch_pc<=fetch_pc+1, wrapping FFFF->0000.
    - If the pushed word has instr[15:12]==HLT_OP, the next state is HALTED. The HLT word itself is buffered and delivered normally.
  - HALTED: im_rd_en=0 and halted=1. Buffered entries, including the HLT, still drain to decode. The block leaves HALTED only on redirect or rst.
- Push and pop in the same cycle: count is unchanged, and a full buffer keeps fetching at full rate.
- if_instr/if_pc come from the buffer head. They are undefined-but-stable when if_valid=0, and must not change while if_valid=1 and dec_ready=0.
- Redirect (highest priority after rst, in any state):
  - count<=0 and pointers reset; any pop that cycle is ignored.
  - fetch_pc<=redirect_pc, state<=RUN, im_rd_en=0 that cycle.
  - The first fetch from the target happens in the next cycle, so if_valid for the target is first seen two cycles after redirect.
- Back-to-back redirects: the last one wins; no fetch occurs between them.
- rst mid-operation discards all buffered words, whatever the state.
- Empty buffer: if_valid=0; dec_ready is ignored.
- Full buffer with no pop: im_rd_en=0, and fetch_pc holds.

Decomposition:
- Shared package (wisc_pkg): HLT_OP constant, instruction/address width constants (16), and the fetch state enum {RUN, HALTED}.
- Natural sub-module: if_buffer, a DEPTH-entry synchronous FIFO of {instr, pc} with push/pop/flush, count, full/empty, and same-cycle push+pop.
- The top level holds the PC, the state machine and the memory request logic.

Test Plan:
- Reset then run, memory holds 0x1111,0x2222,0x3333 at 0..2, dec_ready=1 → im_addr 0,1,2 on consecutive cycles; if_instr 1111/2222/3333 with if_pc 0/1/2 one per cycle.
- dec_ready=0 from reset → two fetches (addr 0,1), then im_rd_en=0 and fetch_pc=2 holds. Raise dec_ready → head 0x1111 pops and fetch of addr 2 resumes the same cycle.
- Redirect to 0x0040 while the buffer is full → next cycle if_valid=0 and im_addr=0x0040; the following cycle if_pc=0x0040. No stale word is ever delivered.
- HLT 0xF000 at address 3 → addresses 0..3 fetched and delivered, halted=1 after the push, im_rd_en stays 0. A later redirect to 0 clears halted and resumes fetching.
- PC wrap, rst with RESET_PC=16'hFFFF → if_pc sequence FFFF, 0000; if_pc_plus1 = 0000 for the FFFF entry.
- rst asserted mid-stream with 2 entries buffered → next cycle if_valid=0, halted=0, im_addr=RESET_PC.
